// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Purpose : shared constants and types for the registered ripple-carry adder.
// Contents: ADDER_WIDTH - default operand/sum width
//           operand_t   - operand type at the default width
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage : adder_pkg

// File: rtl/adder_4bit_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Purpose : single-bit full adder, one link of the ripple-carry chain.
// Ports   : a, b (in)  - operand bits
//           ci   (in)  - carry into this bit
//           s    (out) - sum bit
//           co   (out) - carry out of this bit
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;  // propagate term, shared by sum and carry

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule : full_adder_cell

// File: rtl/adder_4bit.sv
// -----------------------------------------------------------------------------
// adder_4bit
// Purpose : registered ripple-carry adder. {cout, sum} = a + b + cin, with a
//           signed-overflow flag, one clock of latency.
// Ports   : clk       (in)  rising-edge clock
//           rst_n     (in)  asynchronous active-low reset
//           en        (in)  capture enable; operands sampled when high
//           a, b      (in)  WIDTH-bit operands (unsigned / two's complement)
//           cin       (in)  carry-in
//           sum       (out) registered (a + b + cin) mod 2^WIDTH
//           cout      (out) registered carry out of the MSB
//           ovf       (out) registered signed overflow (carry into MSB ^ cout)
//           out_valid (out) result strobe, see below
//
// Valid semantics: out_valid is a pure strobe with no ready. It is high for
// exactly the cycle after each edge on which en was sampled high, so a stream
// of back-to-back captures gives an unbroken out_valid. sum/cout/ovf hold their
// last captured values when out_valid is low.
// -----------------------------------------------------------------------------
module adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // w_c[k] is the carry into bit k; w_c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (w_sum[i]),
            .co (w_c[i+1])
        );
    end

    // Two's-complement overflow: the carry into the sign bit disagrees with
    // the carry out of it.
    assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= en;
            if (en) begin
                r_sum  <= w_sum;
                r_cout <= w_c[WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;

endmodule : adder_4bit

// File: tb/tb_adder_4bit.sv
// -----------------------------------------------------------------------------
// tb_adder_4bit
// Purpose : self-checking bench for adder_4bit (WIDTH = 4).
// -----------------------------------------------------------------------------
module tb_adder_4bit;
    import adder_pkg::*;

    localparam int W = ADDER_WIDTH;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;

    always #5 clk = ~clk;

    adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Expected record layout: {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model ----------------
    function automatic int as_signed(input logic [W-1:0] x);
        return (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
    endfunction

    // Unsigned sum gives {cout,sum}; signed sum out of range gives ovf.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         c);
        int   u;
        int   s;
        logic o;
        u = int'(x) + int'(y) + int'(c);
        s = as_signed(x) + as_signed(y) + int'(c);
        o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        return {o, u[W:0]};
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic e);
        a   = x;
        b   = y;
        cin = c;
        en  = e;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [W+1:0] e,
                             input logic ev);
        check({tag, ".sum"},       32'(sum),       32'(e[W-1:0]));
        check({tag, ".cout"},      32'(cout),      32'(e[W]));
        check({tag, ".ovf"},       32'(ovf),       32'(e[W+1]));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [W+1:0] e;
        logic [W+1:0] last;
        logic         ev;
        logic         r_en;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;

        vecs[0] = '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0};
        vecs[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[2] = '{4'b1001, 4'b1001, 1'b1, 4'b0011, 1'b1, 1'b1};
        vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[6] = '{4'b0101, 4'b0110, 1'b0, 4'b1011, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_out("reset", '0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, issued back-to-back.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            @(negedge clk);
            check_out($sformatf("vec%0d", i),
                      {vecs[i].ovf, vecs[i].cout, vecs[i].sum}, 1'b1);
        end

        // Hold: en low, inputs changing, outputs keep 1011/0/1.
        drive(4'b1010, 4'b0011, 1'b1, 1'b0);
        @(negedge clk);
        check_out("hold1", {1'b1, 1'b0, 4'b1011}, 1'b0);
        drive(4'b1111, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        check_out("hold2", {1'b1, 1'b0, 4'b1011}, 1'b0);

        // No combinational path: new inputs with en high do not move outputs
        // before the edge.
        drive(4'b1111, 4'b1111, 1'b1, 1'b1);
        #1;
        check_out("nocomb", {1'b1, 1'b0, 4'b1011}, 1'b0);
        @(negedge clk);
        check_out("pre_rst", {1'b0, 1'b1, 4'b1111}, 1'b1);

        // Reset mid-cycle with an in-flight capture pending.
        @(posedge clk);
        #2;
        drive(4'b0011, 4'b0100, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", '0, 1'b0);
        @(negedge clk);
        check_out("rst_held", '0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_out("post_rst", {1'b0, 1'b0, 4'b0111}, 1'b1);

        // Exhaustive back-to-back sweep with the scoreboard queue.
        last = '0;
        for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < (1 << W); x++) begin
                for (int y = 0; y < (1 << W); y++) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_out("sweep", e, 1'b1);
                    end
                    exp_q.push_back(model(W'(x), W'(y), 1'(c)));
                    drive(W'(x), W'(y), 1'(c), 1'b1);
                    @(negedge clk);
                end
            end
        end
        e = exp_q.pop_front();
        check_out("sweep_last", e, 1'b1);
        last = e;
        drive('0, '0, 1'b0, 1'b0);

        // Random stimulus with random enable gaps.
        ev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check_out("rand", last, ev);
            r_en = 1'($urandom_range(0, 1));
            rx   = W'($urandom_range(0, (1 << W) - 1));
            ry   = W'($urandom_range(0, (1 << W) - 1));
            rc   = 1'($urandom_range(0, 1));
            drive(rx, ry, rc, r_en);
            if (r_en) last = model(rx, ry, rc);
            ev = r_en;
        end
        @(negedge clk);
        check_out("rand_last", last, ev);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_adder_4bit
